// File: rtl/aes_gf_pkg.sv
// GF(2^8) helpers shared by the AES MixColumns datapath: byte/column types and xtime.
package aes_gf_pkg;

  localparam logic [7:0] AES_POLY = 8'h1B;
  localparam int         AES_NB   = 4;

  typedef logic [7:0]  byte_t;
  typedef logic [31:0] col_t;

  // Multiply by x (02) modulo x^8+x^4+x^3+x+1.
  function automatic byte_t xtime(input byte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
  endfunction

  function automatic byte_t col_byte(input col_t c, input int r);
    return c[8*r +: 8];
  endfunction

endpackage

// File: rtl/aes_mixcol_col.sv
// One AES column: combinational stage-1 xtime terms and stage-2 XOR combine.
// Inverse terms and the E/B/D/9 combine exist only when INV_MIXCOL_EN is defined.
module aes_mixcol_col
  import aes_gf_pkg::*;
(
  input  col_t a_i,
  input  logic inv_i,
  output col_t x2_o,
  output col_t x4_o,
  output col_t x8_o,
  input  col_t s_a_i,
  input  col_t s_x2_i,
  input  col_t s_x4_i,
  input  col_t s_x8_i,
  input  logic s_inv_i,
  output col_t b_o
);

  always_comb begin
    x2_o = '0;
    x4_o = '0;
    x8_o = '0;
    for (int r = 0; r < AES_NB; r++) begin
      x2_o[8*r +: 8] = xtime(col_byte(a_i, r));
`ifdef INV_MIXCOL_EN
      if (inv_i) begin
        x4_o[8*r +: 8] = xtime(col_byte(x2_o, r));
        x8_o[8*r +: 8] = xtime(col_byte(x4_o, r));
      end
`endif
    end
  end

  // 3a = 2a^a; inverse: 9=8+1, B=8+2+1, D=8+4+1, E=8+4+2.
  always_comb begin
    byte_t fwd_b;
    b_o   = '0;
    fwd_b = '0;
    for (int r = 0; r < AES_NB; r++) begin
      fwd_b = col_byte(s_x2_i, r)
            ^ col_byte(s_x2_i, (r + 1) % AES_NB) ^ col_byte(s_a_i, (r + 1) % AES_NB)
            ^ col_byte(s_a_i, (r + 2) % AES_NB)
            ^ col_byte(s_a_i, (r + 3) % AES_NB);
      b_o[8*r +: 8] = fwd_b;
`ifdef INV_MIXCOL_EN
      if (s_inv_i) begin
        b_o[8*r +: 8] =
            (col_byte(s_x8_i, r) ^ col_byte(s_x4_i, r) ^ col_byte(s_x2_i, r))
          ^ (col_byte(s_x8_i, (r + 1) % AES_NB) ^ col_byte(s_x2_i, (r + 1) % AES_NB)
             ^ col_byte(s_a_i, (r + 1) % AES_NB))
          ^ (col_byte(s_x8_i, (r + 2) % AES_NB) ^ col_byte(s_x4_i, (r + 2) % AES_NB)
             ^ col_byte(s_a_i, (r + 2) % AES_NB))
          ^ (col_byte(s_x8_i, (r + 3) % AES_NB) ^ col_byte(s_a_i, (r + 3) % AES_NB));
      end
`endif
    end
  end

`ifndef INV_MIXCOL_EN
  logic unused_inv_terms;
  assign unused_inv_terms = ^{inv_i, s_x4_i, s_x8_i, s_inv_i};
`endif

endmodule

// File: rtl/aes_mixcol_pipe.sv
// Two-stage pipelined AES MixColumns, NCOL columns per beat, valid/ready on both sides.
// Define INV_MIXCOL_EN to build the InvMixColumns path and honour in_inv.
module aes_mixcol_pipe
  import aes_gf_pkg::*;
#(
  parameter int NCOL  = 1,
  parameter int TAG_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_inv,
  input  logic [32*NCOL-1:0]   in_data,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [32*NCOL-1:0]   out_data,
  output logic [TAG_W-1:0]     out_tag,
  output logic                 out_last,
  output logic [1:0]           beat_cnt
);

  localparam int         DW        = 32 * NCOL;
  localparam int         BEATS     = AES_NB / NCOL;
  localparam logic [1:0] LAST_BEAT = 2'(BEATS - 1);

  logic inv_in;
`ifdef INV_MIXCOL_EN
  assign inv_in = in_inv;
`else
  logic unused_in_inv;
  assign unused_in_inv = in_inv;
  assign inv_in        = 1'b0;
`endif

  logic [DW-1:0]    x2_c, x4_c, x8_c, b_c;
  logic             vld_p1_q, vld_p1_d, inv_p1_q;
  logic [TAG_W-1:0] tag_p1_q;
  logic [DW-1:0]    a_p1_q, x2_p1_q, x4_p1_q, x8_p1_q;
  logic             vld_p2_q, vld_p2_d;
  logic [DW-1:0]    data_p2_q;
  logic [TAG_W-1:0] tag_p2_q;
  logic [1:0]       cnt_q, cnt_d;
  logic             s1_rdy, s2_rdy, acc, load_p2, emit;

  for (genvar c = 0; c < NCOL; c++) begin : g_col
    aes_mixcol_col u_col (
      .a_i     (in_data[32*c +: 32]),
      .inv_i   (inv_in),
      .x2_o    (x2_c[32*c +: 32]),
      .x4_o    (x4_c[32*c +: 32]),
      .x8_o    (x8_c[32*c +: 32]),
      .s_a_i   (a_p1_q[32*c +: 32]),
      .s_x2_i  (x2_p1_q[32*c +: 32]),
      .s_x4_i  (x4_p1_q[32*c +: 32]),
      .s_x8_i  (x8_p1_q[32*c +: 32]),
      .s_inv_i (inv_p1_q),
      .b_o     (b_c[32*c +: 32])
    );
  end

  // Ready ripples back from the output so empty stages always absorb a beat.
  assign s2_rdy   = !vld_p2_q || out_ready;
  assign s1_rdy   = !vld_p1_q || s2_rdy;
  assign in_ready = s1_rdy;
  assign acc      = in_valid && s1_rdy;
  assign load_p2  = vld_p1_q && s2_rdy;
  assign emit     = vld_p2_q && out_ready;

  always_comb begin
    vld_p1_d = vld_p1_q;
    vld_p2_d = vld_p2_q;
    cnt_d    = cnt_q;
    if (s1_rdy) vld_p1_d = in_valid;
    if (s2_rdy) vld_p2_d = vld_p1_q;
    if (emit)   cnt_d = (cnt_q == LAST_BEAT) ? 2'd0 : cnt_q + 2'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      vld_p1_q <= vld_p1_d;
      vld_p2_q <= vld_p2_d;
      cnt_q    <= cnt_d;
    end
  end

  // Stage 1: column bytes and xtime terms
  always_ff @(posedge clk) begin
    if (acc) begin
      a_p1_q   <= in_data;
      x2_p1_q  <= x2_c;
      x4_p1_q  <= x4_c;
      x8_p1_q  <= x8_c;
      inv_p1_q <= inv_in;
      tag_p1_q <= in_tag;
    end
  end

  // Stage 2: combined result, cleared on reset so the idle output reads zero
  always_ff @(posedge clk) begin
    if (rst) begin
      data_p2_q <= '0;
      tag_p2_q  <= '0;
    end else if (load_p2) begin
      data_p2_q <= b_c;
      tag_p2_q  <= tag_p1_q;
    end
  end

  assign out_valid = vld_p2_q;
  assign out_data  = data_p2_q;
  assign out_tag   = tag_p2_q;
  assign beat_cnt  = cnt_q;
  assign out_last  = vld_p2_q && (cnt_q == LAST_BEAT);

endmodule
